enum_code_rx: RTL and testbench
===============================

ENUM_CODE_RX -- requirements
Module: enum_code_rx

Interface
REQ-001 SHALL have parameter ERR_LIMIT, default 3: consecutive erroneous words that force RESYNC; legal range 1..15.
REQ-002 SHALL have parameter CNT_W, default 8: width of the statistics counters.
REQ-003 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1: reset, asynchronous and active-high.
REQ-005 SHALL have port in_valid, input, 1: in_code/in_sel are valid.
REQ-006 SHALL have port in_ready, output, 1: the block accepts the word this cycle.
REQ-007 SHALL have port in_sel, input, 2: code class. 0 = 5-bit, 1 = 6-bit, 2 = 7-bit, 3 = 8-bit.
REQ-008 SHALL have port in_code, input, 8: code word, zero-extended from the class width.
REQ-009 SHALL have port out_valid, output, 1: the decoded symbol is held.
REQ-010 SHALL have port out_ready, input, 1: the downstream consumes the symbol.
REQ-011 SHALL have port out_sym, output, 3: decoded symbol index 0..7.
REQ-012 SHALL have port out_err, output, 1: the word did not match its class table.
REQ-013 SHALL have port sync_lost, output, 1: the FSM is in RESYNC.
REQ-014 SHALL have ports good_cnt, err_cnt, drop_cnt, output, CNT_W each: statistics counters.

Function
REQ-015 The code table SHALL be as follows:
- class 0: 5'b00111->0, 5'b11100->1
- class 1: 6'b000111->2, 6'b111000->3
- class 2: 7'b0011100->4, 7'b1100011->5
- class 3: 8'b01011010->6, 8'b11010011->7
REQ-016 Any nonzero in_code bit above the class width, or any non-table value, SHALL be an error word: out_sym=0, out_err=1.
REQ-017 A transfer SHALL occur on a rising edge with in_valid && in_ready.
- The output side transfers on out_valid && out_ready.
REQ-018 in_ready SHALL be combinational and equal (!out_valid || out_ready) in RUN, and 1 in RESYNC.
REQ-019 A word accepted in RUN at edge N SHALL appear on out_valid/out_sym/out_err after edge N.
- Latency 1 cycle; sustained throughput 1 word/cycle while out_ready=1.
REQ-020 While out_valid=1 && out_ready=0, out_sym and out_err SHALL hold stable and no word is accepted.
REQ-021 The FSM SHALL have two states.
- RUN: decode and emit.
- RESYNC: discard input words, never emit.
REQ-022 A 4-bit consecutive-error count SHALL track error words in RUN.
- Increments on each error word accepted in RUN.
- Clears on each good word accepted in RUN.
REQ-023 When an error word accepted in RUN brings the consecutive-error count to ERR_LIMIT:
- That word SHALL still be emitted.
- The FSM SHALL enter RESYNC on the same edge.
REQ-024 In RESYNC, every accepted word SHALL be discarded and drop_cnt increments.
- Exception: class 3 code 8'b01011010 (sync word). It is also discarded without emit, but it returns the FSM to RUN and clears the consecutive-error count.
REQ-025 Entry to RESYNC SHALL NOT cancel a pending output.
- The emitted word remains until consumed by out_ready.
REQ-026 good_cnt SHALL increment per good word accepted in RUN; err_cnt SHALL increment per error word accepted in RUN.
REQ-027 All counters SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-028 Simultaneous output consume and input accept in one cycle SHALL replace the output register with no bubble.
REQ-029 sync_lost SHALL be registered state: 1 exactly while FSM=RESYNC.

Reset
REQ-030 On rst=1, regardless of clk, the block SHALL force:
- state RUN
- out_valid=0, out_sym=0, out_err=0, sync_lost=0
- consecutive-error count 0
- good_cnt=err_cnt=drop_cnt=0
REQ-031 rst asserted mid-operation SHALL discard any pending output word and any partial error run; the word on the input that cycle SHALL NOT be accepted.
REQ-032 After rst deasserts, the block SHALL accept on the first rising edge with in_valid=1.

Verification
REQ-033 Class 0/5'b00111, class 1/6'b111000, class 3/8'b11010011 on three back-to-back cycles, out_ready=1 -> out_sym 0, 3, 7 on consecutive cycles; out_err=0; good_cnt=3.
REQ-034 Class 0 with in_code=8'b10000111 -> out_sym=0, out_err=1, err_cnt=1.
REQ-035 Three errors in a row (ERR_LIMIT=3), then class 2/7'b1100011 -> three error outputs; sync_lost=1 after the third; class-2 word dropped, drop_cnt=1, no output; then class 3/8'b01011010 -> sync_lost=0, no output; next class 2/7'b0011100 -> out_sym=4.
REQ-036 out_ready=0 for 5 cycles holding class 1/6'b000111 output -> out_sym=2 stable, in_ready=0; out_ready=1 with a new input the same cycle -> no bubble.
REQ-037 Counters with CNT_W=2 after 5 good words -> good_cnt=3 (saturated).
REQ-038 rst pulsed asynchronously while out_valid=1 and sync_lost=1 -> immediately out_valid=0, sync_lost=0, all counters 0.

Source files
------------

// File: rtl/enum_code_rx.sv
// Receiver for enumerated fixed-width code words: decodes each word to a symbol index,
// tracks runs of bad words, and drops input until a sync word arrives after too many errors.
module enum_code_rx #(
    parameter int unsigned ERR_LIMIT = 3,
    parameter int unsigned CNT_W     = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_sel,
    input  logic [7:0]       in_code,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2:0]       out_sym,
    output logic             out_err,
    output logic             sync_lost,
    output logic [CNT_W-1:0] good_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic [CNT_W-1:0] drop_cnt
);

    localparam int unsigned RUN_W     = 4;
    localparam logic [RUN_W-1:0] ERR_LIM = RUN_W'(ERR_LIMIT);
    localparam logic [1:0]  SYNC_SEL  = 2'd3;
    localparam logic [7:0]  SYNC_CODE = 8'b0101_1010;

    typedef enum logic {
        RUN    = 1'b0,
        RESYNC = 1'b1
    } state_t;

    state_t           state;
    logic [RUN_W-1:0] err_run;
    logic [2:0]       dec_sym;
    logic             dec_err;
    logic             accept;
    logic             is_sync;

    // Table lookup on the full 8-bit word, so stray bits above the class width miss the table
    always_comb begin
        dec_sym = 3'd0;
        dec_err = 1'b1;
        case (in_sel)
            2'd0: begin
                if (in_code == 8'b0000_0111) begin dec_sym = 3'd0; dec_err = 1'b0; end
                if (in_code == 8'b0001_1100) begin dec_sym = 3'd1; dec_err = 1'b0; end
            end
            2'd1: begin
                if (in_code == 8'b0000_0111) begin dec_sym = 3'd2; dec_err = 1'b0; end
                if (in_code == 8'b0011_1000) begin dec_sym = 3'd3; dec_err = 1'b0; end
            end
            2'd2: begin
                if (in_code == 8'b0001_1100) begin dec_sym = 3'd4; dec_err = 1'b0; end
                if (in_code == 8'b0110_0011) begin dec_sym = 3'd5; dec_err = 1'b0; end
            end
            default: begin
                if (in_code == 8'b0101_1010) begin dec_sym = 3'd6; dec_err = 1'b0; end
                if (in_code == 8'b1101_0011) begin dec_sym = 3'd7; dec_err = 1'b0; end
            end
        endcase
    end

    // RESYNC swallows everything, so it never back-pressures the source
    always_comb begin
        in_ready = 1'b1;
        if (state == RUN) in_ready = !out_valid || out_ready;
    end

    assign accept  = in_valid && in_ready;
    assign is_sync = (in_sel == SYNC_SEL) && (in_code == SYNC_CODE);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= RUN;
            err_run   <= '0;
            out_valid <= 1'b0;
            out_sym   <= 3'd0;
            out_err   <= 1'b0;
            sync_lost <= 1'b0;
            good_cnt  <= '0;
            err_cnt   <= '0;
            drop_cnt  <= '0;
        end else begin
            if (out_valid && out_ready) out_valid <= 1'b0;
            if (accept) begin
                case (state)
                    RUN: begin
                        out_valid <= 1'b1;
                        out_sym   <= dec_sym;
                        out_err   <= dec_err;
                        if (dec_err) begin
                            err_cnt <= sat_inc(err_cnt);
                            err_run <= err_run + RUN_W'(1);
                            // The limit-reaching word is still emitted; input is dropped from next cycle
                            if (err_run + RUN_W'(1) >= ERR_LIM) begin
                                state     <= RESYNC;
                                sync_lost <= 1'b1;
                            end
                        end else begin
                            good_cnt <= sat_inc(good_cnt);
                            err_run  <= '0;
                        end
                    end
                    default: begin
                        drop_cnt <= sat_inc(drop_cnt);
                        if (is_sync) begin
                            state     <= RUN;
                            sync_lost <= 1'b0;
                            err_run   <= '0;
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_enum_code_rx.sv
// Directed bench for enum_code_rx: decode table, error runs, resync, back-pressure, saturation, reset.
module tb_enum_code_rx;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [1:0] in_sel;
    logic [7:0] in_code;
    logic       out_valid;
    logic       out_ready;
    logic [2:0] out_sym;
    logic       out_err;
    logic       sync_lost;
    logic [7:0] good_cnt, err_cnt, drop_cnt;

    logic       in_ready2, out_valid2, out_err2, sync_lost2;
    logic [2:0] out_sym2;
    logic [1:0] good_cnt2, err_cnt2, drop_cnt2;

    int passes = 0;
    int total  = 0;

    enum_code_rx #(.ERR_LIMIT(3), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_sel(in_sel), .in_code(in_code), .out_valid(out_valid), .out_ready(out_ready),
        .out_sym(out_sym), .out_err(out_err), .sync_lost(sync_lost),
        .good_cnt(good_cnt), .err_cnt(err_cnt), .drop_cnt(drop_cnt)
    );

    enum_code_rx #(.ERR_LIMIT(3), .CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2),
        .in_sel(in_sel), .in_code(in_code), .out_valid(out_valid2), .out_ready(out_ready),
        .out_sym(out_sym2), .out_err(out_err2), .sync_lost(sync_lost2),
        .good_cnt(good_cnt2), .err_cnt(err_cnt2), .drop_cnt(drop_cnt2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Drive one cycle of inputs, then sample 1 time unit after the rising edge
    task automatic step(input logic v, input logic [1:0] s, input logic [7:0] c, input logic r);
        in_valid  = v;
        in_sel    = s;
        in_code   = c;
        out_ready = r;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_sel = 2'd0; in_code = 8'd0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_sym",   32'(out_sym),   32'd0);
        chk("rst_out_err",   32'(out_err),   32'd0);
        chk("rst_sync_lost", 32'(sync_lost), 32'd0);
        chk("rst_counters",  32'({good_cnt, err_cnt, drop_cnt}), 32'd0);
        chk("rst_in_ready",  32'(in_ready),  32'd1);
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;

        // Three back-to-back good words
        step(1'b1, 2'd0, 8'b0000_0111, 1'b1);
        chk("b2b_0_valid", 32'(out_valid), 32'd1);
        chk("b2b_0_sym",   32'(out_sym),   32'd0);
        step(1'b1, 2'd1, 8'b0011_1000, 1'b1);
        chk("b2b_1_sym",   32'(out_sym),   32'd3);
        chk("b2b_1_valid", 32'(out_valid), 32'd1);
        step(1'b1, 2'd3, 8'b1101_0011, 1'b1);
        chk("b2b_2_sym",   32'(out_sym),   32'd7);
        chk("b2b_2_err",   32'(out_err),   32'd0);
        chk("b2b_good",    32'(good_cnt),  32'd3);
        step(1'b1, 2'd0, 8'b0001_1100, 1'b1);
        chk("c0_sym1",     32'(out_sym),   32'd1);
        step(1'b1, 2'd1, 8'b0000_0111, 1'b1);
        chk("good5",       32'(good_cnt),  32'd5);
        chk("sat_good2",   32'(good_cnt2), 32'd3);
        step(1'b0, 2'd0, 8'd0, 1'b1);
        chk("drain_valid", 32'(out_valid), 32'd0);

        // Stray bit above class width
        step(1'b1, 2'd0, 8'b1000_0111, 1'b1);
        chk("hibit_sym",   32'(out_sym),   32'd0);
        chk("hibit_err",   32'(out_err),   32'd1);
        chk("hibit_errc",  32'(err_cnt),   32'd1);
        step(1'b1, 2'd2, 8'b0001_1100, 1'b1);
        chk("clear_sym4",  32'(out_sym),   32'd4);

        // Three consecutive errors force RESYNC; last one still emitted
        step(1'b1, 2'd3, 8'h00, 1'b1);
        chk("e1_err",      32'(out_err),   32'd1);
        step(1'b1, 2'd2, 8'h80, 1'b1);
        chk("e2_sync",     32'(sync_lost), 32'd0);
        step(1'b1, 2'd1, 8'h3F, 1'b1);
        chk("e3_valid",    32'(out_valid), 32'd1);
        chk("e3_err",      32'(out_err),   32'd1);
        chk("e3_sync",     32'(sync_lost), 32'd1);
        chk("e3_errc",     32'(err_cnt),   32'd4);
        step(1'b0, 2'd0, 8'd0, 1'b0);
        chk("hold_valid",  32'(out_valid), 32'd1);
        chk("resync_rdy",  32'(in_ready),  32'd1);
        step(1'b1, 2'd2, 8'b0110_0011, 1'b0);
        chk("drop_cnt",    32'(drop_cnt),  32'd1);
        chk("drop_pend",   32'(out_valid), 32'd1);
        chk("drop_sym",    32'(out_err),   32'd1);
        step(1'b0, 2'd0, 8'd0, 1'b1);
        chk("drop_novalid", 32'(out_valid), 32'd0);
        step(1'b1, 2'd3, 8'b0101_1010, 1'b1);
        chk("sync_back",   32'(sync_lost), 32'd0);
        chk("sync_noemit", 32'(out_valid), 32'd0);
        step(1'b1, 2'd2, 8'b0001_1100, 1'b1);
        chk("post_valid",  32'(out_valid), 32'd1);
        chk("post_sym",    32'(out_sym),   32'd4);
        step(1'b0, 2'd0, 8'd0, 1'b1);

        // Back-pressure hold then no-bubble replace
        step(1'b1, 2'd1, 8'b0000_0111, 1'b0);
        chk("bp_sym",      32'(out_sym),   32'd2);
        in_sel = 2'd0; in_code = 8'b0001_1100;
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 2'd0, 8'b0001_1100, 1'b0);
            chk("bp_hold_sym", 32'(out_sym),  32'd2);
            chk("bp_hold_rdy", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        #1;
        chk("bp_rdy_comb", 32'(in_ready),  32'd1);
        @(posedge clk); #1;
        chk("nb_valid",    32'(out_valid), 32'd1);
        chk("nb_sym",      32'(out_sym),   32'd1);
        chk("nb_good",     32'(good_cnt),  32'd9);

        // Asynchronous reset while output pending and in RESYNC
        step(1'b1, 2'd3, 8'h01, 1'b1);
        step(1'b1, 2'd3, 8'h02, 1'b1);
        step(1'b1, 2'd3, 8'h03, 1'b1);
        step(1'b1, 2'd3, 8'h04, 1'b0);
        chk("pre_valid",   32'(out_valid), 32'd1);
        chk("pre_sync",    32'(sync_lost), 32'd1);
        #2 rst = 1'b1;
        in_sel = 2'd0; in_code = 8'b0000_0111;
        #1;
        chk("ar_valid",    32'(out_valid), 32'd0);
        chk("ar_sync",     32'(sync_lost), 32'd0);
        chk("ar_counters", 32'({good_cnt, err_cnt, drop_cnt}), 32'd0);
        @(posedge clk); #1;
        chk("ar_noaccept", 32'(out_valid), 32'd0);
        @(negedge clk) rst = 1'b0;
        step(1'b1, 2'd0, 8'b0000_0111, 1'b1);
        chk("first_valid", 32'(out_valid), 32'd1);
        chk("first_good",  32'(good_cnt),  32'd1);
        step(1'b0, 2'd0, 8'd0, 1'b1);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
